instr_fetch_unit: RTL and testbench

//  Fetch-side producer for the IF/ID pipeline register: owns the PC, issues word reads to

---
 rtl/instr_fetch_unit.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch-side producer for the IF/ID pipeline register. It owns the PC and issues
// one word read at a time to instruction memory over a req/ready handshake. Returned
// words are buffered in a small FIFO, and the FIFO head is presented to IF/ID.
// A redirect flushes the buffer. A fetch that is still in flight when the redirect
// arrives is completed against memory and its data is thrown away.

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_M1_C = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DISCARD
  } fetchState_t;

  fetchState_t r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_req;

  logic [31:0]   r_instrMem [FIFO_DEPTH];
  logic [31:0]   r_pcMem    [FIFO_DEPTH];
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_countAfterPop;
  logic          w_hasSpace;
  logic          w_roomAfterPush;
  logic [31:0]   w_redirectPc;
  logic [31:0]   w_pcPlus4;

  // The buffer level is taken after this cycle's pop. Fetching therefore keeps
  // running at one word per cycle while IF/ID drains the buffer, even when it is full.
  assign w_empty         = (r_count == '0);
  assign w_pop           = !w_empty && !stall_in;
  assign w_push          = (r_state == FETCH_REQ) && imem_ready && !redirect_valid;
  assign w_countAfterPop = r_count - CW'(w_pop);
  assign w_hasSpace      = (w_countAfterPop < DEPTH_C);
  assign w_roomAfterPush = (w_countAfterPop < DEPTH_M1_C);
  assign w_redirectPc    = redirect_pc & 32'hFFFF_FFFC;
  assign w_pcPlus4       = r_pc + 32'd4;

  assign imem_req        = r_req;
  assign imem_addr       = r_addr;
  assign instr_valid     = !w_empty;
  assign instruction_out = w_empty ? 32'd0 : r_instrMem[r_rdPtr];
  assign pc_out          = w_empty ? 32'd0 : r_pcMem[r_rdPtr];

  // Buffer storage: write the accepted word and its PC at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instrMem[r_wrPtr] <= imem_rdata;
      r_pcMem[r_wrPtr]    <= r_pc;
    end
  end

  // Buffer bookkeeping. A redirect empties the buffer, and it takes priority over any push or pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_count <= w_countAfterPop + CW'(w_push);
    end
  end

  // Fetch FSM. It holds the PC and the registered request and address. Once the
  // request is raised it stays up until imem_ready. The address stays fixed while
  // a stale fetch completes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FETCH_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          if (redirect_valid) begin
            r_state <= FETCH_REQ;
            r_pc    <= w_redirectPc;
            r_addr  <= w_redirectPc;
            r_req   <= 1'b1;
          end else if (w_hasSpace) begin
            r_state <= FETCH_REQ;
            r_addr  <= r_pc;
            r_req   <= 1'b1;
          end
        end
        FETCH_REQ: begin
          if (redirect_valid) begin
            r_pc <= w_redirectPc;
            if (imem_ready) begin
              r_addr <= w_redirectPc;
            end else begin
              r_state <= FETCH_DISCARD;
            end
          end else if (imem_ready) begin
            r_pc   <= w_pcPlus4;
            r_addr <= w_pcPlus4;
            if (!w_roomAfterPush) begin
              r_state <= FETCH_IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        FETCH_DISCARD: begin
          if (imem_ready) begin
            r_state <= FETCH_REQ;
            if (redirect_valid) begin
              r_pc   <= w_redirectPc;
              r_addr <= w_redirectPc;
            end else begin
              r_addr <= r_pc;
            end
          end else if (redirect_valid) begin
            r_pc <= w_redirectPc;
          end
        end
        default: begin
          r_state <= FETCH_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Directed bench for the fetch unit. Memory returns each word as its address XOR a
// fixed key, so every expected instruction follows directly from the expected PC.
// A second instance, with a reset PC just below the 32-bit boundary, covers PC wraparound.

module tb_instr_fetch_unit;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        instr_valid;

  logic        reset2;
  logic        imemReq2;
  logic [31:0] imemAddr2;
  logic        imemReady2;
  logic [31:0] imemRdata2;
  logic [31:0] instrOut2;
  logic [31:0] pcOut2;
  logic        instrValid2;

  int checkCount;
  int errorCount;

  assign imem_rdata = imem_addr ^ KEY;
  assign imemRdata2 = imemAddr2 ^ KEY;

  instr_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .instr_valid     (instr_valid)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dutWrap (
    .clk             (clk),
    .reset           (reset2),
    .imem_req        (imemReq2),
    .imem_addr       (imemAddr2),
    .imem_ready      (imemReady2),
    .imem_rdata      (imemRdata2),
    .stall_in        (1'b0),
    .redirect_valid  (1'b0),
    .redirect_pc     (32'd0),
    .instruction_out (instrOut2),
    .pc_out          (pcOut2),
    .instr_valid     (instrValid2)
  );

  // Free-running clock with a 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Drive the main DUT inputs, let one rising edge pass and settle 1 unit after it.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic stl,
                               input logic rv, input logic [31:0] rpc);
    reset          = rst;
    imem_ready     = rdy;
    stall_in       = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Directed sequence. Every check reads values 1 unit after a rising edge.
  initial begin
    checkCount = 0;
    errorCount = 0;
    reset2     = 1'b0;
    imemReady2 = 1'b0;

    // Reset state
    doReset();
    checkOutput("rst_req",   {31'd0, imem_req},    32'd0);
    checkOutput("rst_addr",  imem_addr,            32'd0);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_instr", instruction_out,      32'd0);
    checkOutput("rst_pc",    pc_out,               32'd0);
    checkOutput("rst2_addr", imemAddr2,            32'hFFFF_FFF8);
    checkOutput("rst2_req",  {31'd0, imemReq2},    32'd0);

    // 1: streaming, with memory always ready and no stall
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("s1_req",   {31'd0, imem_req},    32'd1);
    checkOutput("s1_addr0", imem_addr,            32'd0);
    checkOutput("s1_val0",  {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("s1_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("s1_pc",    pc_out,               32'(4 * i));
      checkOutput("s1_instr", instruction_out,      32'(4 * i) ^ KEY);
      checkOutput("s1_addr",  imem_addr,            32'(4 * (i + 1)));
    end

    // 2: continuous stall fills the buffer, then the buffer drains in order
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("s2_req_full", {31'd0, imem_req}, 32'd0);
    checkOutput("s2_head0",    pc_out,            32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("s2_req_hold", {31'd0, imem_req}, 32'd0);
    checkOutput("s2_head0b",   instruction_out,   32'd0 ^ KEY);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("s2_head1",    pc_out,            32'd4);
    checkOutput("s2_instr1",   instruction_out,   32'd4 ^ KEY);
    checkOutput("s2_resume",   {31'd0, imem_req}, 32'd1);
    checkOutput("s2_addr8",    imem_addr,         32'd8);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("s2_head2",    pc_out,            32'd8);
    checkOutput("s2_addr12",   imem_addr,         32'd12);

    // 3: memory holds off ready for 3 cycles on address 0x10
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    end
    checkOutput("s3_pc_c",   pc_out,    32'h0C);
    checkOutput("s3_addr10", imem_addr, 32'h10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("s3_req_wait",  {31'd0, imem_req},    32'd1);
      checkOutput("s3_addr_wait", imem_addr,            32'h10);
      checkOutput("s3_val_wait",  {31'd0, instr_valid}, 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("s3_valid",  {31'd0, instr_valid}, 32'd1);
    checkOutput("s3_pc10",   pc_out,               32'h10);
    checkOutput("s3_instr",  instruction_out,      32'h10 ^ KEY);
    checkOutput("s3_addr14", imem_addr,            32'h14);

    // 4: redirect while the fetch of 0x14 is pending; the buffer is held by a stall
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h203);
    checkOutput("s4_flush",   {31'd0, instr_valid}, 32'd0);
    checkOutput("s4_req",     {31'd0, imem_req},    32'd1);
    checkOutput("s4_addr14",  imem_addr,            32'h14);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("s4_addr_hold", imem_addr,            32'h14);
    checkOutput("s4_val_hold",  {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("s4_stale_drop", {31'd0, instr_valid}, 32'd0);
    checkOutput("s4_addr200",    imem_addr,            32'h200);
    checkOutput("s4_req_new",    {31'd0, imem_req},    32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("s4_pc200",    pc_out,          32'h200);
    checkOutput("s4_instr200", instruction_out, 32'h200 ^ KEY);
    checkOutput("s4_addr204",  imem_addr,       32'h204);

    // 5: redirect in the same cycle that memory returns 0x204
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h300);
    checkOutput("s5_drop",    {31'd0, instr_valid}, 32'd0);
    checkOutput("s5_addr300", imem_addr,            32'h300);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("s5_pc300",   pc_out,               32'h300);
    checkOutput("s5_valid",   {31'd0, instr_valid}, 32'd1);

    // 6: PC wraps past 32'hFFFF_FFFC; reset is then asserted while a fetch is pending
    reset      = 1'b0;
    reset2     = 1'b1;
    imemReady2 = 1'b1;
    @(posedge clk); #1;
    checkOutput("s6_addr_f8", imemAddr2, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    checkOutput("s6_addr_fc", imemAddr2, 32'hFFFF_FFFC);
    checkOutput("s6_pc_f8",   pcOut2,    32'hFFFF_FFF8);
    @(posedge clk); #1;
    checkOutput("s6_addr_0",  imemAddr2, 32'h0);
    checkOutput("s6_pc_fc",   pcOut2,    32'hFFFF_FFFC);
    @(posedge clk); #1;
    checkOutput("s6_pc_0",    pcOut2,    32'h0);
    checkOutput("s6_instr_0", instrOut2, 32'h0 ^ KEY);
    imemReady2 = 1'b0;
    @(posedge clk); #1;
    checkOutput("s6_req_mid", {31'd0, imemReq2}, 32'd1);
    reset2 = 1'b0;
    @(posedge clk); #1;
    checkOutput("s6_rst_req",   {31'd0, imemReq2},    32'd0);
    checkOutput("s6_rst_valid", {31'd0, instrValid2}, 32'd0);
    checkOutput("s6_rst_addr",  imemAddr2,            32'hFFFF_FFF8);
    checkOutput("s6_rst_pc",    pcOut2,               32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
